// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: glyph table and blank levels.
// All outputs are active-low; segment order is {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [2:0] idx_t;

    localparam logic [7:0] AnOff  = 8'hFF;
    localparam logic [6:0] SegOff = 7'h7F;

    // Entry n is the glyph for hex digit n (packed, so entry 15 is written first).
    localparam logic [15:0][6:0] GlyphTable = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    // Pure table lookup; no state lives here.
    always_comb begin
        glyph_o = GlyphTable[nibble_i];
    end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with a frame-synchronous shadow register.
// Optional macro SEG_BLANK_EN blanks leading-zero digits above the top nonzero nibble.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIV    = 50000,
    parameter int unsigned DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [31:0]         disp_in,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [7:0]          an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic                frame
);

    localparam int unsigned    PW      = $clog2(DIV);
    localparam logic [PW-1:0]  PresMax = PW'(DIV - 1);

    logic [PW-1:0]      presc_q, presc_d;
    idx_t               idx_q, idx_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [DIGITS-1:0]  dpsh_q, dpsh_d;
    logic               frame_q, frame_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               tick;
    nibble_t            cur_nibble;
    logic [6:0]         cur_glyph;
    logic               blank;

    assign tick       = en && (presc_q == PresMax);
    assign cur_nibble = shadow_q[4*idx_q +: 4];

    seg_decode u_decode (
        .nibble_i (cur_nibble),
        .glyph_o  (cur_glyph)
    );

`ifdef SEG_BLANK_EN
    idx_t msd;

    // Locate the most-significant nonzero nibble; digit 0 is always the floor.
    always_comb begin
        msd = '0;
        for (int i = 1; i < 8; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) begin
                msd = idx_t'(i);
            end
        end
        blank = (idx_q > msd);
    end
`else
    assign blank = 1'b0;
`endif

    // Prescaler, digit index and frame-boundary snapshot of the display inputs.
    always_comb begin
        presc_d  = presc_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        dpsh_d   = dpsh_q;
        frame_d  = 1'b0;
        if (en) begin
            if (tick) begin
                presc_d = '0;
                idx_d   = idx_q + idx_t'(1);
                if (idx_q == idx_t'(7)) begin
                    shadow_d = disp_in;
                    dpsh_d   = dp_in;
                    frame_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Output drive derived from the current index and shadow; blank while disabled.
    always_comb begin
        an_d  = AnOff;
        seg_d = SegOff;
        dp_d  = 1'b1;
        if (en) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = blank ? SegOff : cur_glyph;
            dp_d  = ~dpsh_q[idx_q];
        end
    end

    // State and registered outputs; idx resets to 7 so the first tick starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= idx_t'(7);
            shadow_q <= '0;
            dpsh_q   <= '0;
            frame_q  <= 1'b0;
            an_q     <= AnOff;
            seg_q    <= SegOff;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            dpsh_q   <= dpsh_d;
            frame_q  <= frame_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with DIV=4 and a behavioural display model.
module tb_seg_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] disp_in = 32'h0;
    logic [7:0]  dp_in = 8'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int checks = 0;
    int failures = 0;

    seg_scan #(.DIV(DIV), .DIGITS(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .disp_in (disp_in),
        .dp_in   (dp_in),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    // Reference model: hold counter, shown digit, latched frame image, expected pins.
    logic [6:0]  glyph [16];
    int          m_cnt;
    int          m_dig;
    logic [31:0] m_img;
    logic [7:0]  m_dpimg;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic        m_frame;

    initial begin
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
        glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
    end

    task automatic model_reset();
        m_cnt = 0; m_dig = 7; m_img = 32'h0; m_dpimg = 8'h0;
        m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_frame = 1'b0;
    endtask

    // One clock edge of the model, from the inputs present at that edge.
    task automatic model_edge();
        int nib;
        int top;
        nib = (m_img >> (4 * m_dig)) & 32'hF;
        top = 0;
        for (int i = 1; i < 8; i++) if (((m_img >> (4 * i)) & 32'hF) != 0) top = i;
        if (en) begin
            m_an  = 8'hFF ^ (8'(1) << m_dig);
            m_seg = glyph[nib];
`ifdef SEG_BLANK_EN
            if (m_dig > top) m_seg = 7'h7F;
`endif
            m_dp  = !m_dpimg[m_dig];
        end else begin
            m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
        end
        m_frame = en && (m_cnt == DIV - 1) && (m_dig == 7);
        if (en) begin
            if (m_cnt == DIV - 1) begin
                if (m_dig == 7) begin
                    m_img = disp_in; m_dpimg = dp_in;
                end
                m_cnt = 0;
                m_dig = (m_dig + 1) % 8;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // Advance one clock; leaves time at 1 unit after the edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic wait_an(input logic [7:0] target, output bit found);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (an === target) found = 1;
        end
    endtask

    task automatic wait_frame(output bit found);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (frame === 1'b1) found = 1;
        end
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        model_reset();
        rst_n = 0; en = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({an, seg, dp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold: got an=%h seg=%h dp=%b frame=%b want ff 7f 1 0",
                     an, seg, dp, frame);
        end
        rst_n = 1; en = 1;
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(); n++;
            checks++;
            if ({an, seg, dp, frame} !== {m_an, m_seg, m_dp, m_frame}) begin
                failures++;
                $display("FAIL reset_release_c%0d: got %h %h %b %b want %h %h %b %b", n,
                         an, seg, dp, frame, m_an, m_seg, m_dp, m_frame);
            end
            if (frame === 1'b1) seen = 1;
        end
        // Frame is visible in cycle DIV+1 counting the released cycle as cycle 1.
        checks++;
        if (!seen || n != DIV) begin
            failures++;
            $display("FAIL first_frame_timing: got edge %0d (seen=%0d) want edge %0d", n, seen, DIV);
        end
        step();
        checks++;
        if (an !== 8'hFE || frame !== 1'b0) begin
            failures++;
            $display("FAIL first_digit_an: got an=%h frame=%b want fe 0", an, frame);
        end
    endtask

    task automatic test_digits();
        logic [6:0] exp_seq [8];
        bit found;
        exp_seq[0] = 7'h00; exp_seq[1] = 7'h78; exp_seq[2] = 7'h02; exp_seq[3] = 7'h12;
        exp_seq[4] = 7'h19; exp_seq[5] = 7'h30; exp_seq[6] = 7'h24; exp_seq[7] = 7'h79;
        disp_in = 32'h1234_5678; dp_in = 8'h00;
        wait_frame(found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL digits_frame_wait: got timeout want frame pulse");
        end
        for (int s = 1; s <= 32; s++) begin
            step();
            checks++;
            if ({an, seg, dp, frame} !== {m_an, m_seg, m_dp, m_frame}) begin
                failures++;
                $display("FAIL digits_model_s%0d: got %h %h %b %b want %h %h %b %b", s,
                         an, seg, dp, frame, m_an, m_seg, m_dp, m_frame);
            end
            if (s % 4 == 1) begin
                checks++;
                if (an !== ~(8'(1) << ((s - 1) / 4)) || seg !== exp_seq[(s - 1) / 4]) begin
                    failures++;
                    $display("FAIL digits_glyph_d%0d: got an=%h seg=%h want an=%h seg=%h",
                             (s - 1) / 4, an, seg, ~(8'(1) << ((s - 1) / 4)), exp_seq[(s - 1) / 4]);
                end
            end
        end
    endtask

    task automatic test_tearing();
        bit found;
        int early_f;
        wait_an(8'hF7, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL tear_wait_d3: got timeout want an=f7");
        end
        disp_in = 32'hFFFF_FFFF;
        early_f = 0;
        for (int i = 0; i < 40 && frame !== 1'b1; i++) begin
            step();
            if (an !== 8'hFF && seg === 7'h0E) early_f++;
            checks++;
            if ({an, seg, dp, frame} !== {m_an, m_seg, m_dp, m_frame}) begin
                failures++;
                $display("FAIL tear_old_i%0d: got %h %h %b %b want %h %h %b %b", i,
                         an, seg, dp, frame, m_an, m_seg, m_dp, m_frame);
            end
        end
        checks++;
        if (early_f != 0) begin
            failures++;
            $display("FAIL tear_leak: got %0d early F glyphs want 0", early_f);
        end
        for (int s = 1; s <= 32; s++) begin
            step();
            checks++;
            if (seg !== 7'h0E) begin
                failures++;
                $display("FAIL tear_new_s%0d: got seg=%h want 0e", s, seg);
            end
        end
    endtask

    task automatic test_enable_gap();
        bit found;
        wait_an(8'hDF, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL gap_wait_d5: got timeout want an=df");
        end
        step();
        en = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL gap_blank_i%0d: got %h %h %b %b want ff 7f 1 0", i,
                         an, seg, dp, frame);
            end
        end
        en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame} !== {m_an, m_seg, m_dp, m_frame}) begin
                failures++;
                $display("FAIL gap_resume_i%0d: got %h %h %b %b want %h %h %b %b", i,
                         an, seg, dp, frame, m_an, m_seg, m_dp, m_frame);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int n;
        bit seen;
        wait_an(8'hBF, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rmid_wait_d6: got timeout want an=bf");
        end
        step();
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({an, seg, dp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rmid_async: got %h %h %b %b want ff 7f 1 0", an, seg, dp, frame);
        end
        step(); step();
        rst_n = 1;
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(); n++;
            checks++;
            if ({an, seg, dp, frame} !== {m_an, m_seg, m_dp, m_frame}) begin
                failures++;
                $display("FAIL rmid_restart_c%0d: got %h %h %b %b want %h %h %b %b", n,
                         an, seg, dp, frame, m_an, m_seg, m_dp, m_frame);
            end
            if (frame === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != DIV) begin
            failures++;
            $display("FAIL rmid_frame_timing: got edge %0d (seen=%0d) want edge %0d", n, seen, DIV);
        end
    endtask

`ifdef SEG_BLANK_EN
    task automatic test_blank();
        bit found;
        disp_in = 32'h0000_00A5; dp_in = 8'h04;
        wait_frame(found);
        for (int s = 1; s <= 32; s++) begin
            step();
            if (s % 4 == 1) begin
                checks++;
                if (seg !== ((s == 1) ? 7'h12 : (s == 5) ? 7'h08 : 7'h7F) ||
                    dp !== ((s == 9) ? 1'b0 : 1'b1)) begin
                    failures++;
                    $display("FAIL blank_d%0d: got seg=%h dp=%b", (s - 1) / 4, seg, dp);
                end
            end
        end
        disp_in = 32'h0;
        wait_frame(found);
        step();
        checks++;
        if (an !== 8'hFE || seg !== 7'h40) begin
            failures++;
            $display("FAIL blank_zero: got an=%h seg=%h want fe 40", an, seg);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) begin
                disp_in = $urandom();
                if ($urandom_range(0, 1) == 0) disp_in = disp_in >> (4 * $urandom_range(0, 7));
                dp_in = 8'($urandom());
            end
            step();
            checks++;
            if ({an, seg, dp, frame} !== {m_an, m_seg, m_dp, m_frame}) begin
                failures++;
                $display("FAIL random_i%0d: got %h %h %b %b want %h %h %b %b", i,
                         an, seg, dp, frame, m_an, m_seg, m_dp, m_frame);
            end
        end
        en = 1;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_tearing();
        test_enable_gap();
        test_reset_mid();
`ifdef SEG_BLANK_EN
        test_blank();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
